// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable width, parity and stop bits.
// Delivers each frame as a one-clk rx_valid pulse with parity/framing status.
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam logic [TW-1:0] HALF_CNT  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_CNT  = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 par_flag;
  logic                 frame_flag;
  logic                 mid_bit;

  assign mid_bit = tick && (tick_cnt == FULL_CNT);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      par_flag   <= 1'b0;
      frame_flag <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;

      case (state)
        // Only a true falling edge starts a frame, so a held-low break line
        // cannot retrigger once its (framing-error) frame has been delivered.
        IDLE: begin
          if (rx_prev && !rx_s) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt == HALF_CNT) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                bit_cnt    <= '0;
                par_flag   <= 1'b0;
                frame_flag <= 1'b0;
                state      <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        // XOR over payload and parity bit must be 0 for even, 1 for odd.
        PAR: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            par_flag <= (^shift) ^ rx_s ^ ODD_PAR;
            state    <= STOP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        // Leaving at mid-stop-bit lets a back-to-back start edge be seen at once.
        STOP: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              state      <= IDLE;
              rx_valid   <= 1'b1;
              rx_data    <= shift;
              parity_err <= (PARITY != 0) && par_flag;
              frame_err  <= frame_flag | ~rx_s;
            end else begin
              frame_flag <= frame_flag | ~rx_s;
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
